i2c_slave_core: RTL and testbench

- I2C target (slave) engine: the far end of the bus driven by the team's I2C master.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, pushes written bytes out on an rx handshake, and pulls read bytes in on a tx handshake.
- Stretches SCL while the local side is not ready. Sits behind an AXI-lite CSR wrapper or connects directly to a local register file.

---
 rtl/i2c_slave_core.sv | 279 +++++++++++++++++++++++++++
 tb/tb_i2c_slave_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_core.sv
// rtl/i2c_slave_core.sv - I2C target engine with input filtering, 7-bit address match,
// rx/tx byte handshakes and SCL stretching while the local side is not ready.
module i2c_slave_core #(
  parameter logic [6:0] P_SLV_ADDR = 7'h50,
  parameter int          P_FILT_LEN = 3
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       EN,
  input  logic       SCL_I,
  input  logic       SDA_I,
  output logic       SCL_O_EN,
  output logic       SDA_O_EN,
  output logic       rx_vld,
  input  logic       rx_rdy,
  output logic [7:0] rx_dat,
  output logic       rx_first,
  output logic       tx_rdy,
  input  logic       tx_vld,
  input  logic [7:0] tx_dat,
  output logic       START_DET,
  output logic       STOP_DET,
  output logic       ADDR_HIT,
  output logic       RD_NACK,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK,
    S_RD_LOAD, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  localparam logic [3:0] FILT_MAX = 4'(P_FILT_LEN - 1);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d, scl_p_q, sda_p_q;
  logic [3:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_dat_q, rx_dat_d;
  logic       rw_q, rw_d, sda_oe_q, sda_oe_d, scl_oe_q, scl_oe_d;
  logic       rx_vld_q, rx_vld_d, rx_first_q, rx_first_d, first_arm_q, first_arm_d;
  logic       tx_rdy_q, tx_rdy_d, busy_q, busy_d;
  logic       start_p_q, start_p_d, stop_p_q, stop_p_d, hit_p_q, hit_p_d, nack_p_q, nack_p_d;
  logic       scl_rise, scl_fall, start_cond, stop_cond;

  // A line's filtered copy follows the synchronized level only after it has differed for P_FILT_LEN cycles.
  always_comb begin
    scl_f_d   = scl_f_q;
    sda_f_d   = sda_f_q;
    scl_cnt_d = '0;
    sda_cnt_d = '0;
    if (!EN) begin
      scl_f_d = 1'b1;
      sda_f_d = 1'b1;
    end else begin
      if (scl_sync_q[1] != scl_f_q) begin
        if (scl_cnt_q == FILT_MAX) scl_f_d = scl_sync_q[1];
        else                       scl_cnt_d = scl_cnt_q + 4'd1;
      end
      if (sda_sync_q[1] != sda_f_q) begin
        if (sda_cnt_q == FILT_MAX) sda_f_d = sda_sync_q[1];
        else                       sda_cnt_d = sda_cnt_q + 4'd1;
      end
    end
  end

  assign scl_rise   = scl_f_q & ~scl_p_q;
  assign scl_fall   = ~scl_f_q & scl_p_q;
  assign start_cond = ~sda_f_q & sda_p_q & scl_f_q;
  assign stop_cond  = sda_f_q & ~sda_p_q & scl_f_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    scl_oe_d    = 1'b0;
    rx_vld_d    = rx_vld_q;
    rx_dat_d    = rx_dat_q;
    rx_first_d  = rx_first_q;
    first_arm_d = first_arm_q;
    tx_rdy_d    = 1'b0;
    busy_d      = busy_q;
    start_p_d   = 1'b0;
    stop_p_d    = 1'b0;
    hit_p_d     = 1'b0;
    nack_p_d    = 1'b0;
    if (rx_vld_q && rx_rdy) rx_vld_d = 1'b0;
    if (!EN) begin
      state_d     = S_IDLE;
      bit_cnt_d   = '0;
      shift_d     = '0;
      tx_shift_d  = '0;
      rw_d        = 1'b0;
      sda_oe_d    = 1'b0;
      rx_vld_d    = 1'b0;
      rx_dat_d    = '0;
      rx_first_d  = 1'b0;
      first_arm_d = 1'b0;
      busy_d      = 1'b0;
    end else if (start_cond) begin
      state_d   = S_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      start_p_d = 1'b1;
    end else if (stop_cond) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
      stop_p_d  = 1'b1;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            if (shift_q[7:1] == P_SLV_ADDR) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
              state_d  = S_ADDR_ACK;
            end else begin
              state_d  = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            hit_p_d  = 1'b1;
            if (rw_q) begin
              state_d = S_RD_LOAD;
            end else begin
              state_d     = S_WR_DATA;
              first_arm_d = 1'b1;
            end
          end
        end
        S_WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shift_d   = {shift_q[6:0], sda_f_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_vld_d    = 1'b1;
              rx_dat_d    = {shift_q[6:0], sda_f_q};
              rx_first_d  = first_arm_q;
              first_arm_d = 1'b0;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b1;
            scl_oe_d  = rx_vld_q & ~rx_rdy;
            bit_cnt_d = '0;
            state_d   = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          scl_oe_d = scl_oe_q & ~(rx_vld_q & rx_rdy);
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = S_WR_DATA;
          end
        end
        S_RD_LOAD: begin
          // The stretch is kept for one more cycle after the load so the MSB settles first.
          if (tx_vld && tx_rdy_q) begin
            tx_shift_d = tx_dat[6:0];
            sda_oe_d   = ~tx_dat[7];
            scl_oe_d   = scl_oe_q;
            bit_cnt_d  = '0;
            state_d    = S_RD_DATA;
          end else begin
            tx_rdy_d = 1'b1;
            scl_oe_d = ~scl_f_q | scl_oe_q;
          end
        end
        S_RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_RD_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (scl_rise && sda_f_q) begin
            nack_p_d = 1'b1;
            state_d  = S_IGNORE;
          end else if (scl_fall) begin
            state_d = S_RD_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_f_q     <= 1'b1;
      sda_f_q     <= 1'b1;
      scl_p_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      scl_cnt_q   <= '0;
      sda_cnt_q   <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_shift_q  <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rx_vld_q    <= 1'b0;
      rx_dat_q    <= '0;
      rx_first_q  <= 1'b0;
      first_arm_q <= 1'b0;
      tx_rdy_q    <= 1'b0;
      busy_q      <= 1'b0;
      start_p_q   <= 1'b0;
      stop_p_q    <= 1'b0;
      hit_p_q     <= 1'b0;
      nack_p_q    <= 1'b0;
    end else begin
      scl_sync_q  <= {scl_sync_q[0], SCL_I};
      sda_sync_q  <= {sda_sync_q[0], SDA_I};
      scl_f_q     <= scl_f_d;
      sda_f_q     <= sda_f_d;
      scl_p_q     <= scl_f_q;
      sda_p_q     <= sda_f_q;
      scl_cnt_q   <= scl_cnt_d;
      sda_cnt_q   <= sda_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      scl_oe_q    <= scl_oe_d;
      rx_vld_q    <= rx_vld_d;
      rx_dat_q    <= rx_dat_d;
      rx_first_q  <= rx_first_d;
      first_arm_q <= first_arm_d;
      tx_rdy_q    <= tx_rdy_d;
      busy_q      <= busy_d;
      start_p_q   <= start_p_d;
      stop_p_q    <= stop_p_d;
      hit_p_q     <= hit_p_d;
      nack_p_q    <= nack_p_d;
    end
  end

  assign SCL_O_EN  = scl_oe_q & EN;
  assign SDA_O_EN  = sda_oe_q & EN;
  assign rx_vld    = rx_vld_q;
  assign rx_dat    = rx_dat_q;
  assign rx_first  = rx_first_q;
  assign tx_rdy    = tx_rdy_q;
  assign START_DET = start_p_q;
  assign STOP_DET  = stop_p_q;
  assign ADDR_HIT  = hit_p_q;
  assign RD_NACK   = nack_p_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_slave_core.sv
// tb/tb_i2c_slave_core.sv - directed bench for i2c_slave_core: open-drain bus model,
// bit-level master tasks, table of write transactions plus read/stretch/Sr/reset/glitch sequences.
`timescale 1ns/1ps
module tb_i2c_slave_core;

  localparam int H = 20;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic       scl_m = 1'b1, sda_m = 1'b1, rx_rdy = 1'b1, tx_vld = 1'b1;
  logic [7:0] tx_dat, rx_dat;
  logic       scl_oe, sda_oe, rx_vld, rx_first, tx_rdy;
  logic       start_det, stop_det, addr_hit, rd_nack, busy;
  logic       scl_bus, sda_bus;

  assign scl_bus = scl_m & ~scl_oe;
  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_core #(.P_SLV_ADDR(7'h50), .P_FILT_LEN(3)) dut (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .SCL_I(scl_bus), .SDA_I(sda_bus),
    .SCL_O_EN(scl_oe), .SDA_O_EN(sda_oe),
    .rx_vld(rx_vld), .rx_rdy(rx_rdy), .rx_dat(rx_dat), .rx_first(rx_first),
    .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_dat(tx_dat),
    .START_DET(start_det), .STOP_DET(stop_det), .ADDR_HIT(addr_hit),
    .RD_NACK(rd_nack), .BUSY(busy)
  );

  logic [7:0] tx_tab [8];
  logic [8:0] rx_log [64];
  int cyc = 0, n_start = 0, n_stop = 0, n_hit = 0, n_nack = 0, n_txrdy = 0, tx_idx = 0;
  int rx_n = 0, n_sdaoe = 0, n_noack = 0, n_strcyc = 0, acc_cyc = 0, rel_cyc = 0;
  logic tx_rdy_prev = 1'b0, scl_oe_prev = 1'b0;
  int n_chk = 0, n_err = 0, last_wait = 0, w2 = 0;

  assign tx_dat = tx_tab[tx_idx[2:0]];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (start_det) n_start = n_start + 1;
    if (stop_det)  n_stop  = n_stop + 1;
    if (addr_hit)  n_hit   = n_hit + 1;
    if (rd_nack)   n_nack  = n_nack + 1;
    if (tx_rdy && !tx_rdy_prev) n_txrdy = n_txrdy + 1;
    if (tx_rdy_prev && !tx_rdy) tx_idx = tx_idx + 1;
    tx_rdy_prev = tx_rdy;
    if (rx_vld && rx_rdy) begin
      rx_log[rx_n[5:0]] = {rx_first, rx_dat};
      rx_n = rx_n + 1;
      acc_cyc = cyc;
    end
    if (sda_oe) n_sdaoe = n_sdaoe + 1;
    if (scl_oe) n_strcyc = n_strcyc + 1;
    if (scl_oe && !sda_oe) n_noack = n_noack + 1;
    if (scl_oe_prev && !scl_oe) rel_cyc = cyc;
    scl_oe_prev = scl_oe;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release();
    int w;
    w = 0;
    scl_m = 1'b1;
    while (scl_bus !== 1'b1 && w < 4000) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    if (w >= 4000) begin
      n_err = n_err + 1;
      $display("FAIL scl_timeout actual=%0d expected=<4000", w);
    end
  endtask

  task automatic m_start();
    sda_m = 1'b1; scl_m = 1'b1;
    cyc_wait(H); sda_m = 1'b0;
    cyc_wait(H); scl_m = 1'b0;
  endtask

  task automatic m_rstart();
    cyc_wait(4); sda_m = 1'b1;
    cyc_wait(H - 4); scl_release();
    cyc_wait(H); sda_m = 1'b0;
    cyc_wait(H); scl_m = 1'b0;
  endtask

  task automatic m_stop();
    cyc_wait(4); sda_m = 1'b0;
    cyc_wait(H - 4); scl_release();
    cyc_wait(H); sda_m = 1'b1;
    cyc_wait(H);
  endtask

  task automatic m_wbit(input logic b);
    cyc_wait(4); sda_m = b;
    cyc_wait(H - 4); scl_release();
    cyc_wait(H); scl_m = 1'b0;
  endtask

  task automatic m_rbit(output logic b);
    cyc_wait(4); sda_m = 1'b1;
    cyc_wait(H - 4); scl_release();
    cyc_wait(H / 2); b = sda_bus;
    cyc_wait(H / 2); scl_m = 1'b0;
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) m_wbit(d[i]);
    m_rbit(ack);
  endtask

  task automatic m_rbyte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      m_rbit(b);
      d[i] = b;
    end
    m_wbit(nack);
  endtask

  typedef struct {
    logic [7:0] addr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       hit;
  } wr_vec_t;

  initial begin
    wr_vec_t vt [4];
    logic ack, ack2;
    logic [7:0] d, dj;
    int s_start, s_stop, s_hit, s_nack, s_tx, s_rx, s_sda, s_noack, s_str;

    vt[0] = '{8'hA0, 2, 8'hA5, 8'h3C, 1'b1};
    vt[1] = '{8'hB0, 1, 8'h11, 8'h00, 1'b0};
    vt[2] = '{8'hA0, 2, 8'hFF, 8'h00, 1'b1};
    vt[3] = '{8'hA2, 2, 8'hFF, 8'h80, 1'b0};
    tx_tab[0] = 8'h5A; tx_tab[1] = 8'hC3; tx_tab[2] = 8'h96; tx_tab[3] = 8'h00;
    tx_tab[4] = 8'h00; tx_tab[5] = 8'h00; tx_tab[6] = 8'h00; tx_tab[7] = 8'h00;

    cyc_wait(5);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc_wait(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_scl_oe", scl_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_rx", {rx_vld, rx_first, rx_dat}, 0);
    check("rst_tx_rdy", tx_rdy, 0);

    for (int k = 0; k < 4; k++) begin
      s_start = n_start; s_stop = n_stop; s_hit = n_hit; s_rx = rx_n; s_sda = n_sdaoe;
      m_start();
      check($sformatf("v%0d_busy", k), busy, 1);
      m_wbyte(vt[k].addr, ack);
      check($sformatf("v%0d_addr_ack", k), ack, !vt[k].hit);
      for (int j = 0; j < vt[k].n; j++) begin
        dj = (j == 0) ? vt[k].d0 : vt[k].d1;
        m_wbyte(dj, ack);
        check($sformatf("v%0d_data%0d_ack", k, j), ack, !vt[k].hit);
      end
      m_stop();
      cyc_wait(10);
      check($sformatf("v%0d_start_det", k), n_start - s_start, 1);
      check($sformatf("v%0d_stop_det", k), n_stop - s_stop, 1);
      check($sformatf("v%0d_addr_hit", k), n_hit - s_hit, vt[k].hit);
      check($sformatf("v%0d_busy_after", k), busy, 0);
      check($sformatf("v%0d_rx_count", k), rx_n - s_rx, vt[k].hit ? vt[k].n : 0);
      if (vt[k].hit) begin
        for (int j = 0; j < vt[k].n; j++) begin
          dj = (j == 0) ? vt[k].d0 : vt[k].d1;
          check($sformatf("v%0d_rx%0d", k, j), rx_log[(s_rx + j) % 64], {(j == 0), dj});
        end
      end else begin
        check($sformatf("v%0d_sda_never", k), n_sdaoe - s_sda, 0);
      end
    end

    s_hit = n_hit; s_nack = n_nack; s_tx = n_txrdy;
    m_start();
    m_wbyte(8'hA1, ack);
    check("rd_addr_ack", ack, 0);
    m_rbyte(1'b0, d);
    check("rd_byte0", d, 8'h5A);
    m_rbyte(1'b1, d);
    check("rd_byte1", d, 8'hC3);
    cyc_wait(10);
    check("rd_nack_pulse", n_nack - s_nack, 1);
    check("rd_ignore_busy", busy, 1);
    check("rd_ignore_sda", sda_oe, 0);
    m_stop();
    cyc_wait(10);
    check("rd_busy_after", busy, 0);
    check("rd_tx_rdy_count", n_txrdy - s_tx, 2);
    check("rd_addr_hit", n_hit - s_hit, 1);

    rx_rdy = 1'b0;
    s_rx = rx_n;
    m_start();
    m_wbyte(8'hA0, ack);
    check("st_addr_ack", ack, 0);
    s_noack = n_noack; s_str = n_strcyc;
    fork
      m_wbyte(8'h77, ack2);
      begin
        w2 = 0;
        while (!rx_vld && w2 < 2000) begin
          @(negedge clk);
          w2++;
        end
        repeat (200) @(negedge clk);
        @(posedge clk); #1 rx_rdy = 1'b1;
      end
    join
    check("st_data_ack", ack2, 0);
    check("st_master_saw_stretch", last_wait > 100, 1);
    check("st_release_cycle", rel_cyc, acc_cyc + 1);
    check("st_ack_held", n_noack - s_noack, 0);
    check("st_stretch_len", n_strcyc - s_str > 150, 1);
    check("st_rx", rx_log[s_rx % 64], {1'b1, 8'h77});
    m_stop();
    cyc_wait(10);

    s_start = n_start; s_stop = n_stop; s_hit = n_hit; s_nack = n_nack; s_tx = n_txrdy; s_rx = rx_n;
    m_start();
    m_wbyte(8'hA0, ack);
    check("sr_addr_w_ack", ack, 0);
    m_wbyte(8'h01, ack);
    check("sr_data_ack", ack, 0);
    m_rstart();
    m_wbyte(8'hA1, ack);
    check("sr_addr_r_ack", ack, 0);
    m_rbyte(1'b1, d);
    check("sr_rd_byte", d, 8'h96);
    m_stop();
    cyc_wait(10);
    check("sr_start_det", n_start - s_start, 2);
    check("sr_stop_det", n_stop - s_stop, 1);
    check("sr_addr_hit", n_hit - s_hit, 2);
    check("sr_rx_count", rx_n - s_rx, 1);
    check("sr_rx", rx_log[s_rx % 64], {1'b1, 8'h01});
    check("sr_tx_rdy_count", n_txrdy - s_tx, 1);
    check("sr_nack", n_nack - s_nack, 1);

    m_start();
    m_wbyte(8'hA1, ack);
    check("rs_addr_ack", ack, 0);
    w2 = 0;
    while (!sda_oe && w2 < 200) begin
      @(negedge clk);
      w2++;
    end
    check("rs_sda_driven", sda_oe, 1);
    check("rs_busy_pre", busy, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("rs_sda_released", sda_oe, 0);
    check("rs_scl_released", scl_oe, 0);
    check("rs_busy", busy, 0);
    cyc_wait(3);
    @(negedge clk) rst_n = 1'b1;
    m_stop();
    cyc_wait(10);

    s_start = n_start;
    @(posedge clk); #1 sda_m = 1'b0;
    @(posedge clk); #1 sda_m = 1'b1;
    cyc_wait(20);
    check("gl_1cyc_no_start", n_start - s_start, 0);
    @(posedge clk); #1 sda_m = 1'b0;
    repeat (2) @(posedge clk);
    #1 sda_m = 1'b1;
    cyc_wait(20);
    check("gl_2cyc_no_start", n_start - s_start, 0);
    check("gl_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
